// File: rtl/instr_loader.sv
// instr_loader: program loader that packs instruction fields arriving over a
// valid/ready handshake into 32-bit instruction words and writes them to
// consecutive instruction-RAM addresses starting at BASE_ADDR.
// Optional feature macro: LOADER_READBACK_EN adds a read-back check of every
// written word; a mismatch sets the sticky error flag.
module instr_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int          DEPTH     = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        fmt,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        s,
  input  logic [3:0]  dest,
  input  logic [3:0]  src2,
  input  logic [3:0]  src1,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic        last,
  output logic        ram_enable,
  output logic        ram_rw,
  output logic [15:0] ram_address,
  output logic [31:0] ram_in,
  input  logic [31:0] ram_out,
  output logic [16:0] word_count,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
`ifdef LOADER_READBACK_EN
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
`endif
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic        last_q;
  logic        handshake;
  logic        restart;
  logic [31:0] encoded;
  logic [16:0] count_inc;
  logic        exit_now;
  logic        reached;
  logic        mismatch;

  assign handshake = in_valid && (state == S_ARMED);
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE));
  assign count_inc = word_count + 17'd1;

  // The exit decision happens in the last state of a word's sequence; the
  // count it compares against DEPTH is the count after this word.
`ifdef LOADER_READBACK_EN
  assign exit_now = (state == S_CHECK);
  assign reached  = (word_count == DEPTH_W);
  assign mismatch = (state == S_CHECK) && (ram_out != ram_in);
`else
  logic unused_ram_out;
  assign unused_ram_out = ^ram_out;
  assign exit_now = (state == S_WRITE);
  assign reached  = (count_inc == DEPTH_W);
  assign mismatch = 1'b0;
`endif

  // Pack the field bundle; the zero padding sits below the format-specific part.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    encoded = 32'd0;
    if (fmt) begin
      encoded = {cond, opcode, s, dest, imm16, 3'b000};
    end else begin
      encoded = {cond, opcode, s, dest, src2, src1, shamt, 6'b000000};
    end
  end

  // Next-state logic of the load sequencer.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_ARMED;
      S_ARMED: if (handshake) state_n = S_WRITE;
`ifdef LOADER_READBACK_EN
      S_WRITE: state_n = S_READ;
      S_READ:  state_n = S_CHECK;
      S_CHECK: state_n = (last_q || reached) ? S_DONE : S_ARMED;
`else
      S_WRITE: state_n = (last_q || reached) ? S_DONE : S_ARMED;
`endif
      S_DONE:  if (start) state_n = S_ARMED;
      default: state_n = S_IDLE;
    endcase
  end

  // State, registered outputs, word capture, counting and sticky error.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      last_q      <= 1'b0;
      in_ready    <= 1'b0;
      ram_enable  <= 1'b0;
      ram_rw      <= 1'b1;
      ram_address <= 16'd0;
      ram_in      <= 32'd0;
      word_count  <= 17'd0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state      <= state_n;
      in_ready   <= (state_n == S_ARMED);
      ram_enable <= (state_n != S_IDLE) && (state_n != S_ARMED) && (state_n != S_DONE);
      ram_rw     <= (state_n != S_WRITE);
      done       <= (state_n == S_DONE);

      // ram_in doubles as the held word for the whole write/read/check sequence.
      if (handshake) begin
        ram_in      <= encoded;
        last_q      <= last;
        ram_address <= BASE_ADDR + word_count[15:0];
      end

      if (restart) begin
        word_count <= 17'd0;
        error      <= 1'b0;
      end else begin
        if (state == S_WRITE) word_count <= count_inc;
        if (mismatch || (exit_now && reached && !last_q)) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed sequence with randomized bundles checked against
// a field-level encoding model, a RAM model and a write log.
module tb_instr_loader;

  typedef struct packed {
    logic        fmt;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  dest;
    logic [3:0]  src2;
    logic [3:0]  src1;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic        last;
  } bundle_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

`ifdef LOADER_READBACK_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 2;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start, start4, in_valid, in_valid4;
  logic        fmt, s, last;
  logic [3:0]  cond, opcode, dest, src2, src1;
  logic [4:0]  shamt;
  logic [15:0] imm16;

  logic        in_ready, ram_enable, ram_rw, done, error;
  logic [15:0] ram_address;
  logic [31:0] ram_in, ram_out;
  logic [16:0] word_count;
  logic        in_ready4, ram_enable4, ram_rw4, done4, error4;
  logic [15:0] ram_address4;
  logic [31:0] ram_in4, ram_out4;
  logic [16:0] word_count4;

  logic [31:0] mem  [0:65535];
  logic [31:0] mem4 [0:65535];
  logic        corrupt = 1'b0;
  wr_t         wlog[$];
  wr_t         wlog4[$];
  int          hs_q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 Clk = ~Clk;

  instr_loader dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .cond(cond), .opcode(opcode), .s(s), .dest(dest), .src2(src2),
    .src1(src1), .shamt(shamt), .imm16(imm16), .last(last),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_address(ram_address),
    .ram_in(ram_in), .ram_out(ram_out), .word_count(word_count),
    .done(done), .error(error)
  );

  instr_loader #(.BASE_ADDR(16'hFFFE), .DEPTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
    .fmt(fmt), .cond(cond), .opcode(opcode), .s(s), .dest(dest), .src2(src2),
    .src1(src1), .shamt(shamt), .imm16(imm16), .last(last),
    .ram_enable(ram_enable4), .ram_rw(ram_rw4), .ram_address(ram_address4),
    .ram_in(ram_in4), .ram_out(ram_out4), .word_count(word_count4),
    .done(done4), .error(error4)
  );

  // RAM models: combinational read, write on the rising edge.
  assign ram_out  = corrupt ? 32'd0 : mem[ram_address];
  assign ram_out4 = mem4[ram_address4];

  always @(posedge Clk) begin
    cyc++;
    if (in_valid && in_ready) hs_q.push_back(cyc);
    if (ram_enable && !ram_rw) begin
      mem[ram_address] <= ram_in;
      wlog.push_back('{a: ram_address, d: ram_in});
    end
    if (ram_enable4 && !ram_rw4) begin
      mem4[ram_address4] <= ram_in4;
      wlog4.push_back('{a: ram_address4, d: ram_in4});
    end
  end

  // Reference encoding, placed field by field from the instruction format.
  function automatic logic [31:0] encode(input bundle_t b);
    logic [31:0] w;
    w = 32'd0;
    w[31:28] = b.cond;
    w[27:24] = b.opcode;
    w[23]    = b.s;
    w[22:19] = b.dest;
    if (b.fmt) begin
      w[18:3] = b.imm16;
    end else begin
      w[18:15] = b.src2;
      w[14:11] = b.src1;
      w[10:6]  = b.shamt;
    end
    return w;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.fmt    = 1'($urandom);
    b.cond   = 4'($urandom);
    b.opcode = 4'($urandom);
    b.s      = 1'($urandom);
    b.dest   = 4'($urandom);
    b.src2   = 4'($urandom);
    b.src1   = 4'($urandom);
    b.shamt  = 5'($urandom);
    b.imm16  = 16'($urandom);
    b.last   = 1'b0;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    start4 = 1'b0;
  endtask

  // Present a bundle and hold it until the handshake edge; returns at the
  // falling edge inside the WRITE cycle.
  task automatic send(input bundle_t b, input bit sel);
    int n;
    {fmt, cond, opcode, s, dest, src2, src1, shamt, imm16, last} = b;
    if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
    n = 0;
    while (!(sel ? in_ready4 : in_ready) && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("in_ready_wait", sel ? in_ready4 : in_ready, 1'b1);
    @(negedge Clk);
    in_valid = 1'b0;
    in_valid4 = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (!(sel ? done4 : done) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("done_wait", sel ? done4 : done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t     b;
    logic [31:0] exp_q[$];

    Reset = 1'b1;
    {start, start4, in_valid, in_valid4} = '0;
    {fmt, cond, opcode, s, dest, src2, src1, shamt, imm16, last} = '0;
    repeat (2) @(negedge Clk);

    // Reset state
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ram_enable", ram_enable, 1'b0);
    check("rst_ram_rw", ram_rw, 1'b1);
    check("rst_ram_address", ram_address, 16'd0);
    check("rst_ram_in", ram_in, 32'd0);
    check("rst_word_count", word_count, 17'd0);
    check("rst_done_error", {done, error}, 2'b00);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_in_ready", in_ready, 1'b0);

    // Register format, single word
    pulse_start(1'b0);
    check("armed_in_ready", in_ready, 1'b1);
    b = '{fmt: 1'b0, cond: 4'hE, opcode: 4'h1, s: 1'b1, dest: 4'd5, src2: 4'd3,
          src1: 4'd2, shamt: 5'd4, imm16: 16'hBEEF, last: 1'b1};
    send(b, 1'b0);
    check("reg_ram_enable", ram_enable, 1'b1);
    check("reg_ram_rw", ram_rw, 1'b0);
    check("reg_ram_address", ram_address, 16'd0);
    check("reg_ram_in", ram_in, 32'hE1A99100);
    check("reg_model", ram_in, encode(b));
    wait_done(1'b0);
    check("reg_word_count", word_count, 17'd1);
    check("reg_error", error, 1'b0);
    check("done_in_ready", in_ready, 1'b0);

    // Move-immediate format with garbage in the unused fields
    pulse_start(1'b0);
    check("restart_done", done, 1'b0);
    check("restart_count", word_count, 17'd0);
    b = '{fmt: 1'b1, cond: 4'hE, opcode: 4'hD, s: 1'b0, dest: 4'd1, src2: 4'hF,
          src1: 4'hA, shamt: 5'h1F, imm16: 16'h00FF, last: 1'b1};
    send(b, 1'b0);
    check("mov_ram_in", ram_in, 32'hED0807F8);
    check("mov_ram_address", ram_address, 16'd0);
    wait_done(1'b0);

    // Ten random bundles, last on the tenth
    pulse_start(1'b0);
    wlog.delete();
    hs_q.delete();
    for (int i = 0; i < 10; i++) begin
      b = rand_bundle();
      b.last = (i == 9);
      exp_q.push_back(encode(b));
      send(b, 1'b0);
    end
    wait_done(1'b0);
    check("ten_word_count", word_count, 17'd10);
    check("ten_error", error, 1'b0);
    check("ten_log_size", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      check($sformatf("ten_addr%0d", i), wlog[i].a, 16'(i));
      check($sformatf("ten_data%0d", i), wlog[i].d, exp_q[i]);
      check($sformatf("ten_fetch%0d", i), mem[i], exp_q[i]);
    end
    for (int i = 1; i < hs_q.size(); i++) begin
      check($sformatf("ten_gap%0d", i), hs_q[i] - hs_q[i-1], GAP);
    end

    // DEPTH=4 overflow with address wrap from 16'hFFFE
    exp_q.delete();
    wlog4.delete();
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      b = rand_bundle();
      exp_q.push_back(encode(b));
      send(b, 1'b1);
    end
    wait_done(1'b1);
    check("ovf_error", error4, 1'b1);
    check("ovf_word_count", word_count4, 17'd4);
    b = rand_bundle();
    {fmt, cond, opcode, s, dest, src2, src1, shamt, imm16, last} = b;
    in_valid4 = 1'b1;
    repeat (10) @(negedge Clk);
    check("ovf_in_ready", in_ready4, 1'b0);
    in_valid4 = 1'b0;
    check("ovf_log_size", wlog4.size(), 4);
    for (int i = 0; i < 4 && i < wlog4.size(); i++) begin
      check($sformatf("ovf_addr%0d", i), wlog4[i].a, 16'(16'hFFFE + i));
      check($sformatf("ovf_data%0d", i), wlog4[i].d, exp_q[i]);
    end
    pulse_start(1'b1);
    check("ovf_restart_error", error4, 1'b0);
    check("ovf_restart_count", word_count4, 17'd0);
    check("ovf_restart_done", done4, 1'b0);
    b = rand_bundle();
    b.last = 1'b1;
    send(b, 1'b1);
    check("wrap_first_addr", ram_address4, 16'hFFFE);
    wait_done(1'b1);
    check("last_at_one_error", error4, 1'b0);

`ifdef LOADER_READBACK_EN
    // Read-back mismatch: the RAM returns zero for the whole load
    pulse_start(1'b0);
    corrupt = 1'b1;
    b = rand_bundle();
    b.cond = 4'hF;
    send(b, 1'b0);
    b = rand_bundle();
    b.cond = 4'h3;
    b.last = 1'b1;
    send(b, 1'b0);
    wait_done(1'b0);
    corrupt = 1'b0;
    check("rb_error", error, 1'b1);
    check("rb_word_count", word_count, 17'd2);
    pulse_start(1'b0);
    check("rb_restart_error", error, 1'b0);
`endif

    // Asynchronous reset in the middle of a WRITE
    pulse_start(1'b0);
    b = rand_bundle();
    send(b, 1'b0);
    b = rand_bundle();
    send(b, 1'b0);
    check("mid_ram_enable", ram_enable, 1'b1);
    check("mid_word_count", word_count, 17'd1);
    Reset = 1'b1;
    #1;
    check("async_ram_enable", ram_enable, 1'b0);
    check("async_ram_rw", ram_rw, 1'b1);
    check("async_word_count", word_count, 17'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_in_ready", in_ready, 1'b0);
    check("post_rst_done", done, 1'b0);
    check("post_rst_ram_enable", ram_enable, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
